fp_to_int_conv: RTL and testbench

Multi-cycle converter from IEEE-754 single precision to 32-bit two's-complement integer. It consumes words in the format that fadd produces. It uses the same round-to-nearest-even rule as the adder and flags out-of-range inputs on ovf, matching fadd's error signalling. Valid/ready handshakes on both sides; an iterative shifter with a small FSM sits between the FPU result bus and integer consumers.

---
 rtl/fp_to_int_conv.sv | 188 ++++++++++++++++++
 tb/tb_fp_to_int_conv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int_conv.sv
// IEEE-754 single to int32 converter: iterative shifter, round-to-nearest-even, ovf on NaN/Inf/range.
// Optional build macro FTOI_TRUNC_EN adds a per-operand trunc input (round toward zero).
module fp_to_int_conv #(
    parameter int STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        a,
`ifdef FTOI_TRUNC_EN
    input  logic               trunc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] res,
    output logic               ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

    state_t      state;
    logic        sign_r;
    logic        left_r;
    logic        g_r;
    logic        st_r;
    logic [31:0] acc_r;
    logic [4:0]  cnt_r;
    logic        trunc_sel;

`ifdef FTOI_TRUNC_EN
    logic trunc_r;
    assign trunc_sel = trunc_r;
`else
    assign trunc_sel = 1'b0;
`endif

    function automatic logic round_inc(input logic g, input logic st, input logic lsb,
                                       input logic trunc_mode);
        return g & (st | lsb) & ~trunc_mode;
    endfunction

    function automatic logic signed [31:0] apply_sign(input logic s, input logic [31:0] mag);
        logic signed [31:0] m;
        m = $signed(mag);
        return s ? -m : m;
    endfunction

    logic [7:0]        exp_u;
    logic signed [9:0] exp_s;
    logic signed [9:0] diff;
    logic              spec_hit;
    logic [31:0]       spec_res;
    logic              spec_ovf;
    logic [4:0]        n_acc;
    logic              left_acc;

    // Operand decode at accept: special-case result or shift direction/count.
    always_comb begin
        exp_u    = a[30:23];
        exp_s    = $signed({2'b00, exp_u}) - 10'sd127;
        spec_hit = 1'b1;
        spec_res = 32'h0000_0000;
        spec_ovf = 1'b0;
        n_acc    = 5'd0;
        left_acc = 1'b0;
        diff     = 10'sd0;
        if (exp_u == 8'd0) begin
            spec_res = 32'h0000_0000;
        end else if (exp_u == 8'hFF) begin
            spec_ovf = 1'b1;
            spec_res = (a[31] || a[22:0] != 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (exp_s >= 10'sd31) begin
            if (a == 32'hCF00_0000) begin
                spec_res = 32'h8000_0000;
            end else begin
                spec_ovf = 1'b1;
                spec_res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            spec_hit = 1'b0;
            if (exp_s >= 10'sd23) begin
                diff     = exp_s - 10'sd23;
                left_acc = 1'b1;
            end else begin
                diff = 10'sd23 - exp_s;
                if (diff > 10'sd25) diff = 10'sd25;
            end
            n_acc = diff[4:0];
        end
    end

    logic [31:0] acc_nx;
    logic        g_nx;
    logic        st_nx;
    logic [4:0]  cnt_nx;

    // Up to STEP single-bit shifts per cycle; the last cycle stops when the count runs out.
    always_comb begin
        acc_nx = acc_r;
        g_nx   = g_r;
        st_nx  = st_r;
        cnt_nx = cnt_r;
        for (int i = 0; i < STEP; i++) begin
            if (cnt_nx != 5'd0) begin
                if (left_r) begin
                    acc_nx = {acc_nx[30:0], 1'b0};
                end else begin
                    st_nx  = st_nx | g_nx;
                    g_nx   = acc_nx[0];
                    acc_nx = {1'b0, acc_nx[31:1]};
                end
                cnt_nx = cnt_nx - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            ovf       <= 1'b0;
            sign_r    <= 1'b0;
            left_r    <= 1'b0;
            g_r       <= 1'b0;
            st_r      <= 1'b0;
            acc_r     <= '0;
            cnt_r     <= '0;
`ifdef FTOI_TRUNC_EN
            trunc_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_r   <= a[31];
                        acc_r    <= {8'h00, 1'b1, a[22:0]};
                        g_r      <= 1'b0;
                        st_r     <= 1'b0;
                        cnt_r    <= n_acc;
                        left_r   <= left_acc;
`ifdef FTOI_TRUNC_EN
                        trunc_r  <= trunc;
`endif
                        if (spec_hit) begin
                            res       <= $signed(spec_res);
                            ovf       <= spec_ovf;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else if (n_acc == 5'd0) begin
                            state <= ROUND;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc_r <= acc_nx;
                    g_r   <= g_nx;
                    st_r  <= st_nx;
                    cnt_r <= cnt_nx;
                    if (cnt_nx == 5'd0) state <= ROUND;
                end
                ROUND: begin
                    res       <= apply_sign(sign_r,
                                   acc_r + {31'd0, round_inc(g_r, st_r, acc_r[0], trunc_sel)});
                    ovf       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Directed bench for fp_to_int_conv: STEP=1 and STEP=4 instances, hand-computed vectors.
module tb_fp_to_int_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               in_valid, in_ready, out_valid, out_ready, ovf;
    logic [31:0]        a;
    logic signed [31:0] res;
    logic               in_valid4, in_ready4, out_valid4, out_ready4, ovf4;
    logic [31:0]        a4;
    logic signed [31:0] res4;
`ifdef FTOI_TRUNC_EN
    logic trunc  = 1'b0;
    logic trunc4 = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    fp_to_int_conv #(.STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
`ifdef FTOI_TRUNC_EN
        .trunc(trunc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .ovf(ovf)
    );

    fp_to_int_conv #(.STEP(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4),
`ifdef FTOI_TRUNC_EN
        .trunc(trunc4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .res(res4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] av, input logic [31:0] exp_r,
                       input logic exp_o, input int exp_lat);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a = av;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, res, exp_r);
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_o});
        if (exp_lat > 0) chk({tag, "_lat"}, lat, exp_lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run4(input string tag, input logic [31:0] av, input logic [31:0] exp_r,
                        input int exp_lat);
        int w;
        int lat;
        w = 0;
        while (!in_ready4 && w < 100) begin @(negedge clk); w++; end
        chk({tag, "_in_ready"}, {31'd0, in_ready4}, 32'd1);
        a4 = av;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!out_valid4 && lat < 100);
        chk({tag, "_res"}, res4, exp_r);
        chk({tag, "_ovf"}, {31'd0, ovf4}, 32'd0);
        chk({tag, "_lat"}, lat, exp_lat);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        #1 chk("release_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("release_in_ready_high", {31'd0, in_ready}, 32'd1);
        chk("release_in_ready4_high", {31'd0, in_ready4}, 32'd1);

        run("p1_5",    32'h3FC0_0000, 32'd2,          1'b0, 25);
        run("p2_5",    32'h4020_0000, 32'd2,          1'b0, 24);
        run("m3_5",    32'hC060_0000, 32'hFFFF_FFFC,  1'b0, 0);
        run("p0_5",    32'h3F00_0000, 32'd0,          1'b0, 26);
        run("p0_5ulp", 32'h3F00_0001, 32'd1,          1'b0, 0);
        run("p1_0",    32'h3F80_0000, 32'd1,          1'b0, 0);
        run("m1_0",    32'hBF80_0000, 32'hFFFF_FFFF,  1'b0, 0);
        run("e23",     32'h4B00_0000, 32'h0080_0000,  1'b0, 2);
        run("max_fin", 32'h4EFF_FFFF, 32'h7FFF_FF80,  1'b0, 9);
        run("int_min", 32'hCF00_0000, 32'h8000_0000,  1'b0, 1);
        run("pos_big", 32'h4F00_0000, 32'h7FFF_FFFF,  1'b1, 1);
        run("neg_big", 32'hD000_0000, 32'h8000_0000,  1'b1, 1);
        run("nan",     32'h7FC0_0000, 32'h8000_0000,  1'b1, 1);
        run("pinf",    32'h7F80_0000, 32'h7FFF_FFFF,  1'b1, 1);
        run("ninf",    32'hFF80_0000, 32'h8000_0000,  1'b1, 1);
        run("denorm",  32'h0000_0001, 32'd0,          1'b0, 1);
        run("nzero",   32'h8000_0000, 32'd0,          1'b0, 1);

        run4("s4_p1_5",    32'h3FC0_0000, 32'd2,         8);
        run4("s4_max_fin", 32'h4EFF_FFFF, 32'h7FFF_FF80, 4);
        run4("s4_p0_5ulp", 32'h3F00_0001, 32'd1,         8);

`ifdef FTOI_TRUNC_EN
        trunc = 1'b1;
        run("trunc_m3_5", 32'hC060_0000, 32'hFFFF_FFFD, 1'b0, 0);
        trunc = 1'b0;
        run("rne_m3_5",   32'hC060_0000, 32'hFFFF_FFFC, 1'b0, 0);
        trunc = 1'b1;
        run("trunc_pinf", 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1);
        trunc = 1'b0;
`endif

        // Backpressure: result held while out_ready stays low.
        a = 32'h4020_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_res", res, 32'd2);
            chk("hold_ovf", {31'd0, ovf}, 32'd0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of a long conversion.
        a = 32'h3FC0_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midrst_release_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("midrst_release_high", {31'd0, in_ready}, 32'd1);
        repeat (30) @(negedge clk);
        chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        run("post_rst", 32'h4020_0000, 32'd2, 1'b0, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
